// File: rtl/rom_256x8.sv
// rtl/rom_256x8.sv - 256x8 sine lookup ROM with registered address; `ROM_OUTREG_EN adds an output register.
// Quarter-wave table of 65 words, mirrored across 64 and complemented for the second half-period.
module rom_256x8 (
    input  logic       clock,
    input  logic       aclr,
    input  logic [7:0] address,
    output logic [7:0] q
);
    logic [7:0] r_addr_q;
    logic [6:0] w_half;
    logic [6:0] w_fold;
    logic [7:0] w_quarter;
    logic [7:0] w_data;

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_addr_q <= 8'd0;
        end else begin
            r_addr_q <= address;
        end
    end

    assign w_half = r_addr_q[6:0];
    // 65..127 fold back onto 63..1 (128 - h, computed modulo 128)
    assign w_fold = (w_half > 7'd64) ? (7'd0 - w_half) : w_half;

    always_comb begin
        w_quarter = 8'd0;
        case (w_fold)
            7'd0:  w_quarter = 8'd128;
            7'd1:  w_quarter = 8'd131;
            7'd2:  w_quarter = 8'd134;
            7'd3:  w_quarter = 8'd137;
            7'd4:  w_quarter = 8'd140;
            7'd5:  w_quarter = 8'd143;
            7'd6:  w_quarter = 8'd146;
            7'd7:  w_quarter = 8'd149;
            7'd8:  w_quarter = 8'd152;
            7'd9:  w_quarter = 8'd155;
            7'd10: w_quarter = 8'd158;
            7'd11: w_quarter = 8'd162;
            7'd12: w_quarter = 8'd165;
            7'd13: w_quarter = 8'd167;
            7'd14: w_quarter = 8'd170;
            7'd15: w_quarter = 8'd173;
            7'd16: w_quarter = 8'd176;
            7'd17: w_quarter = 8'd179;
            7'd18: w_quarter = 8'd182;
            7'd19: w_quarter = 8'd185;
            7'd20: w_quarter = 8'd188;
            7'd21: w_quarter = 8'd190;
            7'd22: w_quarter = 8'd193;
            7'd23: w_quarter = 8'd196;
            7'd24: w_quarter = 8'd198;
            7'd25: w_quarter = 8'd201;
            7'd26: w_quarter = 8'd203;
            7'd27: w_quarter = 8'd206;
            7'd28: w_quarter = 8'd208;
            7'd29: w_quarter = 8'd211;
            7'd30: w_quarter = 8'd213;
            7'd31: w_quarter = 8'd215;
            7'd32: w_quarter = 8'd218;
            7'd33: w_quarter = 8'd220;
            7'd34: w_quarter = 8'd222;
            7'd35: w_quarter = 8'd224;
            7'd36: w_quarter = 8'd226;
            7'd37: w_quarter = 8'd228;
            7'd38: w_quarter = 8'd230;
            7'd39: w_quarter = 8'd232;
            7'd40: w_quarter = 8'd234;
            7'd41: w_quarter = 8'd235;
            7'd42: w_quarter = 8'd237;
            7'd43: w_quarter = 8'd238;
            7'd44: w_quarter = 8'd240;
            7'd45: w_quarter = 8'd241;
            7'd46: w_quarter = 8'd243;
            7'd47: w_quarter = 8'd244;
            7'd48: w_quarter = 8'd245;
            7'd49: w_quarter = 8'd246;
            7'd50: w_quarter = 8'd248;
            7'd51: w_quarter = 8'd249;
            7'd52: w_quarter = 8'd250;
            7'd53: w_quarter = 8'd250;
            7'd54: w_quarter = 8'd251;
            7'd55: w_quarter = 8'd252;
            7'd56: w_quarter = 8'd253;
            7'd57: w_quarter = 8'd253;
            7'd58: w_quarter = 8'd254;
            7'd59: w_quarter = 8'd254;
            7'd60: w_quarter = 8'd254;
            7'd61: w_quarter = 8'd255;
            7'd62: w_quarter = 8'd255;
            7'd63: w_quarter = 8'd255;
            7'd64: w_quarter = 8'd255;
            default: w_quarter = 8'd0;
        endcase
    end

    // Second half-period is 255 - first half, except the exact zero crossing at 128
    assign w_data = (r_addr_q[7] && (w_half != 7'd0)) ? ~w_quarter : w_quarter;

`ifdef ROM_OUTREG_EN
    logic [7:0] r_q;

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_q <= 8'h00;
        end else begin
            r_q <= w_data;
        end
    end

    assign q = r_q;
`else
    assign q = w_data;
`endif

endmodule

// File: tb/tb_rom_256x8.sv
// tb/tb_rom_256x8.sv - self-checking bench for rom_256x8 against a real-arithmetic sine model.
module tb_rom_256x8;

`ifdef ROM_OUTREG_EN
    localparam int LAT = 2;
    localparam logic [7:0] RST_Q = 8'h00;
`else
    localparam int LAT = 1;
    localparam logic [7:0] RST_Q = 8'h80;
`endif

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } vec_t;

    logic       clock = 1'b0;
    logic       aclr;
    logic [7:0] address;
    logic [7:0] q;

    int         dtab [256];
    int         pipe [$];
    int         sa [$];
    logic [7:0] so [$];
    vec_t       tv [7];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clock = ~clock;

    rom_256x8 dut (
        .clock   (clock),
        .aclr    (aclr),
        .address (address),
        .q       (q)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // The output value sequence is a delay line of depth LAT; front is what q shows now.
    task automatic model_reset();
        pipe.delete();
        if (LAT == 2) pipe.push_back(0);
        pipe.push_back(dtab[0]);
    endtask

    task automatic tick(input string name);
        @(posedge clock);
        if (!aclr) begin
            pipe.push_back(dtab[address]);
            void'(pipe.pop_front());
        end
        #2;
        check(name, q, 8'(pipe[0]));
    endtask

    // Apply sa[] back to back, collect q so that so[i + LAT - 1] belongs to sa[i].
    task automatic run_capture(input string name);
        so.delete();
        foreach (sa[i]) begin
            address = 8'(sa[i]);
            tick(name);
            so.push_back(q);
        end
        for (int j = 0; j < LAT - 1; j++) begin
            address = 8'd0;
            tick(name);
            so.push_back(q);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) begin
            real v;
            v = 128.0 + 127.5 * $sin(2.0 * 3.14159265358979323846 * a / 256.0);
            dtab[a] = int'($floor(v));
        end

        tv[0] = '{8'd0,   8'd128};
        tv[1] = '{8'd32,  8'd218};
        tv[2] = '{8'd64,  8'd255};
        tv[3] = '{8'd96,  8'd218};
        tv[4] = '{8'd128, 8'd128};
        tv[5] = '{8'd160, 8'd37};
        tv[6] = '{8'd192, 8'd0};

        // Reset held for 3 cycles with address 0x40, then release mid-cycle
        address = 8'h40;
        aclr = 1'b1;
        #1;
        model_reset();
        check("reset_initial", q, RST_Q);
        for (int i = 0; i < 3; i++) begin
            tick("reset_hold_model");
            check("reset_hold", q, RST_Q);
        end
        #1 aclr = 1'b0;
        for (int i = 0; i < LAT; i++) tick("reset_release_model");
        check("reset_release_255", q, 8'd255);

        // Anchor table
        sa.delete();
        foreach (tv[i]) sa.push_back(int'(tv[i].addr));
        run_capture("anchor_model");
        foreach (tv[i]) check("anchor", so[i + LAT - 1], tv[i].exp);

        // Full sweep, 10 wraps
        for (int c = 0; c < 2560; c++) begin
            address = 8'(c);
            tick("sweep");
        end
        address = 8'd255;
        tick("wrap_model");
        address = 8'd0;
        tick("wrap_model");
        for (int i = 0; i < LAT - 1; i++) tick("wrap_model");
        check("wrap_to_zero", q, 8'd128);

        // Symmetry about 64 and 192: each read is compared with the model of its mirror
        sa.delete();
        for (int k = 0; k <= 64; k++) begin
            sa.push_back(64 + k);
            sa.push_back(64 - k);
            sa.push_back((192 + k) % 256);
            sa.push_back(192 - k);
        end
        run_capture("sym_model");
        for (int k = 0; k <= 64; k++) begin
            check("sym64_hi",  so[4 * k + LAT - 1], 8'(dtab[64 - k]));
            check("sym64_lo",  so[4 * k + 1 + LAT - 1], 8'(dtab[64 + k]));
            check("sym192_hi", so[4 * k + 2 + LAT - 1], 8'(dtab[192 - k]));
            check("sym192_lo", so[4 * k + 3 + LAT - 1], 8'(dtab[(192 + k) % 256]));
        end

        // Mid-sweep asynchronous reset at address 100
        for (int c = 90; c <= 100; c++) begin
            address = 8'(c);
            tick("midrst_pre");
        end
        #1 aclr = 1'b1;
        #1;
        check("midrst_async", q, RST_Q);
        model_reset();
        address = 8'd101;
        tick("midrst_hold_model");
        check("midrst_hold", q, RST_Q);
        #1 aclr = 1'b0;
        address = 8'd102;
        tick("midrst_post");
        for (int i = 0; i < LAT - 1; i++) begin
            address = 8'(103 + i);
            tick("midrst_post");
        end
        check("midrst_first_word", q, 8'(dtab[102]));
        for (int c = 104; c < 130; c++) begin
            address = 8'(c);
            tick("midrst_sweep");
        end

        // Random back-to-back access
        for (int i = 0; i < 1000; i++) begin
            address = 8'($urandom_range(0, 255));
            tick("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
